// File: rtl/rgb_to_grey_pipe.sv
// rgb_to_grey_pipe: two-stage colour-to-greyscale converter with valid/ready
// streams on both sides. Stage 1 registers the weighted channel products (or
// the channel maximum), stage 2 sums, optionally rounds, scales and saturates.
// Optional feature macro: GREY_ROUND_EN (round-half-up before the shift;
// truncation when undefined).
module rgb_to_grey_pipe #(
  parameter int DW     = 8,
  parameter int COEF_W = 8
) (
  input  logic              sys_clk_i,
  input  logic              sys_rst_ni,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [DW-1:0]     red_dt_i,
  input  logic [DW-1:0]     green_dt_i,
  input  logic [DW-1:0]     blue_dt_i,
  input  logic              s_last_i,
  input  logic [1:0]        mode_i,
  input  logic [COEF_W-1:0] coef_r_i,
  input  logic [COEF_W-1:0] coef_g_i,
  input  logic [COEF_W-1:0] coef_b_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DW-1:0]     grey_dt_o,
  output logic              m_last_o,
  output logic [31:0]       pix_cnt_o
);

  typedef enum logic [1:0] {
    MODE_PROG  = 2'd0,
    MODE_BT601 = 2'd1,
    MODE_MAX   = 2'd2,
    MODE_AVG   = 2'd3
  } mode_e;

  // Product width and sum width (three products need two guard bits).
  localparam int PW = DW + COEF_W;
  localparam int SW = PW + 2;

  // Fixed weights, rounded to the nearest representable fraction of 1.0.
  localparam longint unsigned ONE = 64'd1 << COEF_W;
  localparam logic [COEF_W-1:0] BT_R = COEF_W'((64'd299 * ONE + 64'd500) / 64'd1000);
  localparam logic [COEF_W-1:0] BT_G = COEF_W'((64'd587 * ONE + 64'd500) / 64'd1000);
  localparam logic [COEF_W-1:0] BT_B = COEF_W'((64'd114 * ONE + 64'd500) / 64'd1000);
  localparam logic [COEF_W-1:0] AVG_W = COEF_W'((ONE + 64'd1) / 64'd3);

  localparam logic [DW-1:0] GREY_MAX = {DW{1'b1}};

  // Stage 1 state
  logic          s1_valid;
  logic          s1_is_max;
  logic [DW-1:0] s1_max;
  logic [PW-1:0] s1_p_r, s1_p_g, s1_p_b;
  logic          s1_last;

  // Stage 2 state (drives the output port directly)
  logic          s2_valid;
  logic [DW-1:0] s2_grey;
  logic          s2_last;

  logic [31:0]   pix_cnt;

  // Stage advance: a stage moves when it is empty or its consumer takes its
  // content, so bubbles collapse even while the output is stalled.
  logic adv1, adv2;
  assign adv2 = !s2_valid || m_ready_i;
  assign adv1 = !s1_valid || adv2;

  assign s_ready_o = adv1;
  assign m_valid_o = s2_valid;
  assign grey_dt_o = s2_grey;
  assign m_last_o  = s2_last;
  assign pix_cnt_o = pix_cnt;

  // Weight selection for the incoming pixel and the channel maximum.
  logic [COEF_W-1:0] w_r, w_g, w_b;
  logic [DW-1:0]     ch_max;

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_r = coef_r_i;
    w_g = coef_g_i;
    w_b = coef_b_i;
    case (mode_e'(mode_i))
      MODE_BT601: begin
        w_r = BT_R;
        w_g = BT_G;
        w_b = BT_B;
      end
      MODE_AVG: begin
        w_r = AVG_W;
        w_g = AVG_W;
        w_b = AVG_W;
      end
      default: ;
    endcase

    ch_max = red_dt_i;
    if (green_dt_i > ch_max) ch_max = green_dt_i;
    if (blue_dt_i > ch_max)  ch_max = blue_dt_i;
  end

  // Stage 1: capture products or the maximum for an accepted pixel.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: the datapath registers are few and are reset as well, so the
  // output data reads a defined 0 after reset rather than stale content.
  always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
    if (!sys_rst_ni) begin
      s1_valid  <= 1'b0;
      s1_is_max <= 1'b0;
      s1_max    <= '0;
      s1_p_r    <= '0;
      s1_p_g    <= '0;
      s1_p_b    <= '0;
      s1_last   <= 1'b0;
    end else if (adv1) begin
      s1_valid <= s_valid_i;
      if (s_valid_i) begin
        s1_is_max <= (mode_e'(mode_i) == MODE_MAX);
        s1_max    <= ch_max;
        s1_p_r    <= PW'(red_dt_i)   * PW'(w_r);
        s1_p_g    <= PW'(green_dt_i) * PW'(w_g);
        s1_p_b    <= PW'(blue_dt_i)  * PW'(w_b);
        s1_last   <= s_last_i;
      end
    end
  end

  // Stage 2 arithmetic: sum, optional rounding, scale back, saturate.
  logic [SW-1:0] sum;
  logic [SW-1:0] scaled;
  logic [DW-1:0] grey_next;

  // Combinational result for the pixel currently held in stage 1.
  always_comb begin
    sum = SW'(s1_p_r) + SW'(s1_p_g) + SW'(s1_p_b);
`ifdef GREY_ROUND_EN
    sum = sum + (SW'(1) << (COEF_W - 1));
`else
    sum = sum;
`endif
    scaled = sum >> COEF_W;
    if (s1_is_max) begin
      grey_next = s1_max;
    end else if (scaled > SW'(GREY_MAX)) begin
      grey_next = GREY_MAX;
    end else begin
      grey_next = scaled[DW-1:0];
    end
  end

  // Stage 2: output register, held while the consumer stalls.
  always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
    if (!sys_rst_ni) begin
      s2_valid <= 1'b0;
      s2_grey  <= '0;
      s2_last  <= 1'b0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_grey <= grey_next;
        s2_last <= s1_last;
      end
    end
  end

  // Output handshake counter, wraps naturally at 2^32.
  always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
    if (!sys_rst_ni) begin
      pix_cnt <= '0;
    end else if (s2_valid && m_ready_i) begin
      pix_cnt <= pix_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_rgb_to_grey_pipe.sv
// tb_rgb_to_grey_pipe: directed and randomized checks of rgb_to_grey_pipe
// against a queue-based reference model of the greyscale arithmetic.
module tb_rgb_to_grey_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid, s_ready;
  logic [7:0]  red, green, blue;
  logic        s_last;
  logic [1:0]  mode;
  logic [7:0]  coef_r, coef_g, coef_b;
  logic        m_valid, m_ready;
  logic [7:0]  grey;
  logic        m_last;
  logic [31:0] pix_cnt;

  rgb_to_grey_pipe #(.DW(8), .COEF_W(8)) dut (
    .sys_clk_i  (clk),
    .sys_rst_ni (rst_n),
    .s_valid_i  (s_valid),
    .s_ready_o  (s_ready),
    .red_dt_i   (red),
    .green_dt_i (green),
    .blue_dt_i  (blue),
    .s_last_i   (s_last),
    .mode_i     (mode),
    .coef_r_i   (coef_r),
    .coef_g_i   (coef_g),
    .coef_b_i   (coef_b),
    .m_valid_o  (m_valid),
    .m_ready_i  (m_ready),
    .grey_dt_o  (grey),
    .m_last_o   (m_last),
    .pix_cnt_o  (pix_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: weighted sum in plain integer arithmetic.
  function automatic int ref_grey(input int md, input int r, input int g, input int b,
                                  input int cr, input int cg, input int cb);
    int wr, wg, wb, s;
    case (md)
      0: begin wr = cr; wg = cg; wb = cb; end
      1: begin wr = 77; wg = 150; wb = 29; end
      3: begin wr = 85; wg = 85; wb = 85; end
      default: begin wr = 0; wg = 0; wb = 0; end
    endcase
    if (md == 2) begin
      s = r;
      if (g > s) s = g;
      if (b > s) s = b;
      return s;
    end
    s = r * wr + g * wg + b * wb;
`ifdef GREY_ROUND_EN
    s = s + 128;
`endif
    s = s / 256;
    return (s > 255) ? 255 : s;
  endfunction

`ifdef GREY_ROUND_EN
  localparam int EXP_RED = 77;
  localparam int EXP_AVG = 60;
`else
  localparam int EXP_RED = 76;
  localparam int EXP_AVG = 59;
`endif

  typedef struct {
    int grey;
    bit last;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned out_cnt = 0;
  int unsigned in_cnt  = 0;

  // Scoreboard: sample both handshakes mid-cycle, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      exp_q.delete();
      out_cnt = 0;
    end else begin
      if (m_valid && m_ready) begin
        check("pix_cnt_track", pix_cnt, out_cnt);
        if (exp_q.size() == 0) begin
          check("out_unexpected", m_valid, 0);
        end else begin
          e = exp_q.pop_front();
          check("grey", grey, e.grey);
          check("last", m_last, e.last);
        end
        out_cnt++;
      end
      if (s_valid && s_ready) begin
        e.grey = ref_grey(int'(mode), int'(red), int'(green), int'(blue),
                          int'(coef_r), int'(coef_g), int'(coef_b));
        e.last = s_last;
        exp_q.push_back(e);
        in_cnt++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int md, input int r, input int g, input int b,
                       input int cr, input int cg, input int cb, input bit lst);
    s_valid = v;
    mode    = 2'(md);
    red     = 8'(r);
    green   = 8'(g);
    blue    = 8'(b);
    coef_r  = 8'(cr);
    coef_g  = 8'(cg);
    coef_b  = 8'(cb);
    s_last  = lst;
  endtask

  // Asynchronous reset pulse placed away from clock edges.
  task automatic pulse_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
  endtask

  task automatic drain(input string tag);
    int c = 0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    while ((exp_q.size() != 0 || m_valid) && c < 50) begin
      step();
      c++;
    end
    check(tag, (c < 50), 1);
  endtask

  int idx;
  int stalled_valid;
  bit hs;
  int bp_val[4] = '{11, 22, 33, 44};

  initial begin
    rst_n   = 1'b0;
    m_ready = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    check("rst_m_valid", m_valid, 0);
    check("rst_grey", grey, 0);
    check("rst_m_last", m_last, 0);
    check("rst_pix_cnt", pix_cnt, 0);
    #2 rst_n = 1'b1;
    #1;
    check("rst_s_ready", s_ready, 1);

    // Latency: presented after edge 0, accepted at edge 1, visible after edge 2
    m_ready = 1'b1;
    step();
    drive(1, 1, 255, 0, 0, 0, 0, 0, 0);
    step();
    s_valid = 1'b0;
    check("lat_early_valid", m_valid, 0);
    step();
    check("lat_valid", m_valid, 1);
    check("lat_grey_red", grey, EXP_RED);
    step();

    // Four modes on consecutive cycles, no cross-talk
    drive(1, 1, 255, 255, 255, 0, 0, 0, 0);
    step();
    drive(1, 0, 255, 255, 255, 200, 200, 200, 0);
    step();
    check("mode1_white", grey, 255);
    drive(1, 2, 10, 200, 30, 0, 0, 0, 0);
    step();
    check("mode0_sat", grey, 255);
    drive(1, 3, 30, 60, 90, 0, 0, 0, 1);
    step();
    s_valid = 1'b0;
    check("mode2_max", grey, 200);
    step();
    check("mode3_avg", grey, EXP_AVG);
    check("mode3_last", m_last, 1);
    step();
    check("modes_empty", m_valid, 0);

    // Back-pressure: capacity of two, stable output, ordered release
    pulse_reset();
    m_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      drive(idx < 4, 2, bp_val[idx % 4], bp_val[idx % 4] / 2, 0, 0, 0, 0, idx == 3);
      #3 hs = s_valid && s_ready;
      step();
      if (hs) idx++;
      if (c >= 2) check("bp_stable_grey", grey, bp_val[0]);
    end
    check("bp_accepted", idx, 2);
    check("bp_s_ready", s_ready, 0);
    check("bp_m_valid", m_valid, 1);
    m_ready = 1'b1;
    for (int c = 0; c < 20 && idx < 4; c++) begin
      drive(1, 2, bp_val[idx], bp_val[idx] / 2, 0, 0, 0, 0, idx == 3);
      #3 hs = s_valid && s_ready;
      step();
      if (hs) idx++;
    end
    check("bp_all_accepted", idx, 4);
    drain("bp_drain_timeout");
    check("bp_pix_cnt", pix_cnt, 4);

    // Random valid/ready traffic over 10 000 pixels
    begin
      int unsigned target = in_cnt + 10000;
      int cyc = 0;
      while (in_cnt < target && cyc < 60000) begin
        drive($urandom_range(0, 9) < 7, $urandom_range(0, 3),
              $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
              $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
              $urandom_range(0, 7) == 0);
        m_ready = ($urandom_range(0, 9) < 6);
        step();
        cyc++;
      end
      check("rand_budget", (in_cnt >= target), 1);
      drain("rand_drain_timeout");
      check("rand_pix_cnt", pix_cnt, out_cnt);
    end

    // Reset mid-stream with two pixels in flight and pix_cnt at 7
    pulse_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive(1, 1, i * 30, 100, 200 - i, 0, 0, 0, i == 6);
      step();
    end
    drain("pre_rst_drain_timeout");
    check("pre_rst_pix_cnt", pix_cnt, 7);
    m_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1, 2, 90 + i, 5, 7, 0, 0, 0, 1);
      step();
    end
    s_valid = 1'b0;
    check("pre_rst_full", m_valid, 1);
    check("pre_rst_s_ready", s_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_m_valid", m_valid, 0);
    check("midrst_grey", grey, 0);
    check("midrst_m_last", m_last, 0);
    check("midrst_pix_cnt", pix_cnt, 0);
    check("midrst_s_ready", s_ready, 1);
    m_ready = 1'b1;
    step();
    #2 rst_n = 1'b1;
    stalled_valid = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (m_valid) stalled_valid++;
    end
    check("post_rst_no_stale", stalled_valid, 0);
    check("post_rst_pix_cnt", pix_cnt, 0);
    drive(1, 3, 30, 60, 90, 0, 0, 0, 0);
    step();
    s_valid = 1'b0;
    step();
    check("post_rst_first", grey, EXP_AVG);
    drain("post_rst_drain_timeout");
    check("post_rst_cnt", pix_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
